nn_phase_scheduler: RTL and testbench
=====================================

// Module: nn_phase_scheduler
// PURPOSE
//  Training/validation sequencer for one hidden + one output neuron layer (Q8.8, BITS-wide).
//  Walks samples and epochs and drives the layer phase enables fph/fpo/bph/bpo for fixed dwell times.
//  Emits a sample-load strobe and index toward the dataset store, and busy/done status.
//  Sits between the top-level run control and the Neuron_* instances.
// PARAMETERS
//  BITS       16   datapath width, Q8.8 signed
//  N_SAMPLES  4    samples per epoch (>=1)
//  N_EPOCHS   100  epochs per training run (>=1)
//  FP_CYC     6    cycles each forward phase is held (>=1)
//  BP_CYC     6    cycles each backward phase is held (>=1)
// PORTS
//  clk         in   1                  clock, rising edge
//  rst         in   1                  asynchronous, active-high reset
//  start       in   1                  begin run; sampled in IDLE only
//  stop        in   1                  synchronous abort; priority over everything except rst
//  tr_mode     in   1                  1=train, 0=validate; latched on the accepted start
//  err         in   BITS               output-neuron error (signed Q8.8); used only with LOSS_ACC_EN
//  smp_ld      out  1                  1-cycle strobe: fetch sample smp_idx
//  smp_idx     out  $clog2(N_SAMPLES)  current sample index (width min 1)
//  epoch_cnt   out  $clog2(N_EPOCHS)   current epoch (width min 1)
//  fph,fpo     out  1                  forward-hidden / forward-output enables
//  bph,bpo     out  1                  backward-hidden / backward-output enables
//  busy        out  1                  high in every state except IDLE
//  done        out  1                  1-cycle pulse at run completion
//  epoch_loss  out  BITS               sum of |err| over the last completed epoch
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0. Outputs are registered (Moore, decoded from state).
//  States: IDLE, LOAD, FWD_H, FWD_O, BWD_O, BWD_H, NEXT, DONE.
//  IDLE --start--> LOAD. start in any other state is ignored.
//  LOAD: 1 cycle, smp_ld=1 -> FWD_H.
//  FWD_H: fph=1 for FP_CYC cycles -> FWD_O: fpo=1 for FP_CYC cycles.
//  FWD_O exit: train -> BWD_O; validate -> NEXT.
//  BWD_O: bpo=1 for BP_CYC cycles -> BWD_H: bph=1 for BP_CYC cycles -> NEXT.
//  At most one phase enable high in any cycle. Dwell counts by a down-counter loaded on state entry.
//  NEXT: 1 cycle.
//   - smp_idx < N_SAMPLES-1: smp_idx++, -> LOAD.
//   - Else smp_idx wraps to 0.
//   - Train: epoch_cnt == N_EPOCHS-1 -> DONE; otherwise epoch_cnt++ and -> LOAD.
//   - Validate: always -> DONE (exactly one epoch).
//  DONE: done=1 for 1 cycle -> IDLE. smp_idx/epoch_cnt hold final values until the next accepted start clears them.
//  Cycles per sample: train 2+2*FP_CYC+2*BP_CYC; validate 2+2*FP_CYC.
//  stop: next state IDLE; enables, smp_ld and busy low next cycle; done not pulsed; counters cleared to 0.
//  stop and start together in IDLE: stop wins, no run starts.
//  rst mid-run: immediate return to reset values.
// CONFIGURATION
//  Macro LOSS_ACC_EN.
//  Defined:
//   - err is sampled in the last FWD_O cycle of each sample.
//   - acc += |err|, saturating at 16'h7FFF; |0x8000| is taken as 0x7FFF.
//   - acc is cleared in LOAD when smp_idx==0.
//   - epoch_loss <= acc (including the current sample) in NEXT on wrap; it holds otherwise.
//  Not defined: err is ignored, no accumulator is built, epoch_loss is tied to 0.
// STRUCTURE
//  nn_pkg: state enum typedef sched_state_t; Q8.8 constants Q_ONE=16'h0100 and Q_SAT_MAX=16'h7FFF.
//  Sub-module phase_timer: loadable down-counter with load value and zero flag, width $clog2(max(FP_CYC,BP_CYC)+1).
// TESTING  (N_SAMPLES=2, N_EPOCHS=2, FP_CYC=2, BP_CYC=3; start accepted at edge 0)
//  1. Train run:
//     - LOAD at cycle 1; fph 2-3, fpo 4-5, bpo 6-8, bph 9-11, NEXT 12.
//     - Pattern repeats every 12 cycles for 4 samples; done=1 at cycle 49 only.
//     - epoch_cnt reads 1 from cycle 25.
//  2. Validate (tr_mode=0):
//     - no bph/bpo ever asserted; per sample fph 2-3, fpo 4-5.
//     - done at cycle 13; epoch_cnt stays 0.
//  3. stop asserted at cycle 7 (during bpo):
//     - cycle 8: all enables 0, busy 0, counters 0, no done.
//     - A fresh start is accepted normally.
//  4. rst pulsed mid-FWD_H: outputs 0 asynchronously.
//     start pulses during busy and start+stop in IDLE: no effect.
//  5. LOSS_ACC_EN with err=16'hFF00 (-1.0) every sample:
//     - epoch_loss = 16'h0200 after epoch 0.
//     - With err=16'h8000: saturates at 16'h7FFF.
//     - Without the macro: epoch_loss stays 0.

Source files
------------

// File: rtl/nn_phase_scheduler_pkg.sv
// Shared types and Q8.8 constants for the neuron-layer phase scheduler.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE, LOAD, FWD_H, FWD_O, BWD_O, BWD_H, NEXT, DONE
    } sched_state_t;

    localparam logic [15:0] Q_ONE     = 16'h0100;
    localparam logic [15:0] Q_SAT_MAX = 16'h7FFF;

    // Counter width for an index range of n values, never narrower than 1 bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_phase_scheduler_if.sv
// Run-control / layer-enable bundle between the run controller (master) and the scheduler (slave).
interface nn_phase_scheduler_if #(
    parameter int BITS      = 16,
    parameter int N_SAMPLES = 4,
    parameter int N_EPOCHS  = 100
);
    import nn_pkg::*;

    localparam int SMP_W = clog2_min1(N_SAMPLES);
    localparam int EP_W  = clog2_min1(N_EPOCHS);

    logic                   start;
    logic                   stop;
    logic                   tr_mode;
    logic signed [BITS-1:0] err;
    logic                   smp_ld;
    logic [SMP_W-1:0]       smp_idx;
    logic [EP_W-1:0]        epoch_cnt;
    logic                   fph;
    logic                   fpo;
    logic                   bph;
    logic                   bpo;
    logic                   busy;
    logic                   done;
    logic [BITS-1:0]        epoch_loss;

    modport master (
        output start, stop, tr_mode, err,
        input  smp_ld, smp_idx, epoch_cnt, fph, fpo, bph, bpo, busy, done, epoch_loss
    );

    modport slave (
        input  start, stop, tr_mode, err,
        output smp_ld, smp_idx, epoch_cnt, fph, fpo, bph, bpo, busy, done, epoch_loss
    );

endinterface

// File: rtl/nn_phase_scheduler_phase_timer.sv
// Loadable dwell down-counter; load wins over counting, holds at zero, o_zero flags the last dwell cycle.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/nn_phase_scheduler.sv
// Sample/epoch sequencer driving fph/fpo/bpo/bph dwell phases with registered Moore outputs.
// Optional |err| epoch-loss accumulator built only when LOSS_ACC_EN is defined.
module nn_phase_scheduler
    import nn_pkg::*;
#(
    parameter int BITS      = 16,
    parameter int N_SAMPLES = 4,
    parameter int N_EPOCHS  = 100,
    parameter int FP_CYC    = 6,
    parameter int BP_CYC    = 6
) (
    input  logic              clk,
    input  logic              rst,
    nn_phase_scheduler_if.slave bus
);

    localparam int SMP_W   = clog2_min1(N_SAMPLES);
    localparam int EP_W    = clog2_min1(N_EPOCHS);
    localparam int DWELL_M = (FP_CYC > BP_CYC) ? FP_CYC : BP_CYC;
    localparam int TMR_W   = $clog2(DWELL_M + 1);

    localparam logic [TMR_W-1:0] FP_LD    = TMR_W'(FP_CYC - 1);
    localparam logic [TMR_W-1:0] BP_LD    = TMR_W'(BP_CYC - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(N_SAMPLES - 1);
    localparam logic [EP_W-1:0]  EP_LAST  = EP_W'(N_EPOCHS - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic             r_tr_mode;
    logic [SMP_W-1:0] r_smp_idx;
    logic [EP_W-1:0]  r_epoch_cnt;
    logic             w_smp_wrap;
    logic             w_last_epoch;
    logic             w_tmr_load;
    logic             w_tmr_zero;
    logic [TMR_W-1:0] w_tmr_val;
    logic             r_smp_ld;
    logic             r_fph;
    logic             r_fpo;
    logic             r_bpo;
    logic             r_bph;
    logic             r_busy;
    logic             r_done;

    assign w_smp_wrap   = (r_smp_idx == SMP_LAST);
    assign w_last_epoch = (r_epoch_cnt == EP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tmr_val    = '0;
        if (bus.stop) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.start) w_state_next = LOAD;
                LOAD:    w_state_next = FWD_H;
                FWD_H:   if (w_tmr_zero) w_state_next = FWD_O;
                FWD_O:   if (w_tmr_zero) w_state_next = r_tr_mode ? BWD_O : NEXT;
                BWD_O:   if (w_tmr_zero) w_state_next = BWD_H;
                BWD_H:   if (w_tmr_zero) w_state_next = NEXT;
                NEXT: begin
                    if (!w_smp_wrap || (r_tr_mode && !w_last_epoch)) begin
                        w_state_next = LOAD;
                    end else begin
                        w_state_next = DONE;
                    end
                end
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
        case (w_state_next)
            FWD_H, FWD_O: w_tmr_val = FP_LD;
            BWD_O, BWD_H: w_tmr_val = BP_LD;
            default:      w_tmr_val = '0;
        endcase
    end

    // Reload the dwell on every state change so each phase starts a fresh count.
    assign w_tmr_load = (w_state_next != r_state);

    phase_timer #(.W(TMR_W)) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tr_mode   <= 1'b0;
            r_smp_idx   <= '0;
            r_epoch_cnt <= '0;
        end else if (bus.stop) begin
            r_smp_idx   <= '0;
            r_epoch_cnt <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_tr_mode   <= bus.tr_mode;
            r_smp_idx   <= '0;
            r_epoch_cnt <= '0;
        end else if (r_state == NEXT) begin
            if (!w_smp_wrap) begin
                r_smp_idx <= r_smp_idx + 1'b1;
            end else begin
                r_smp_idx <= '0;
                if (r_tr_mode && !w_last_epoch) begin
                    r_epoch_cnt <= r_epoch_cnt + 1'b1;
                end
            end
        end
    end

    // Decoding the next state keeps the registered outputs aligned with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp_ld <= 1'b0;
            r_fph    <= 1'b0;
            r_fpo    <= 1'b0;
            r_bpo    <= 1'b0;
            r_bph    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_smp_ld <= (w_state_next == LOAD);
            r_fph    <= (w_state_next == FWD_H);
            r_fpo    <= (w_state_next == FWD_O);
            r_bpo    <= (w_state_next == BWD_O);
            r_bph    <= (w_state_next == BWD_H);
            r_busy   <= (w_state_next != IDLE);
            r_done   <= (w_state_next == DONE);
        end
    end

    assign bus.smp_ld    = r_smp_ld;
    assign bus.fph       = r_fph;
    assign bus.fpo       = r_fpo;
    assign bus.bpo       = r_bpo;
    assign bus.bph       = r_bph;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.smp_idx   = r_smp_idx;
    assign bus.epoch_cnt = r_epoch_cnt;

`ifdef LOSS_ACC_EN
    localparam logic [BITS-1:0] SAT = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] NEG_MAX = {1'b1, {(BITS-1){1'b0}}};

    logic [BITS-1:0] r_acc;
    logic [BITS-1:0] r_loss;
    logic [BITS-1:0] w_abs;
    logic [BITS:0]   w_sum;
    logic [BITS-1:0] w_acc_sat;

    // The most negative code has no positive twin, so it folds onto the max.
    always_comb begin
        w_abs = bus.err;
        if (bus.err[BITS-1]) begin
            w_abs = (bus.err == NEG_MAX) ? SAT : -bus.err;
        end
    end

    assign w_sum     = {1'b0, r_acc} + {1'b0, w_abs};
    assign w_acc_sat = (w_sum > {1'b0, SAT}) ? SAT : w_sum[BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_loss <= '0;
        end else begin
            if (r_state == LOAD && r_smp_idx == '0) begin
                r_acc <= '0;
            end else if (r_state == FWD_O && w_tmr_zero) begin
                r_acc <= w_acc_sat;
            end
            if (r_state == NEXT && w_smp_wrap) begin
                r_loss <= r_acc;
            end
        end
    end

    assign bus.epoch_loss = r_loss;
`else
    logic w_unused_err;
    assign w_unused_err   = ^bus.err;
    assign bus.epoch_loss = '0;
`endif

endmodule

// File: tb/tb_nn_phase_scheduler.sv
// Directed bench for nn_phase_scheduler: train, validate, stop, reset and idle start/stop cases.
module tb_nn_phase_scheduler;
    import nn_pkg::*;

    localparam int BITS = 16;
    localparam int NS   = 2;
    localparam int NE   = 2;
    localparam int FP   = 2;
    localparam int BP   = 3;

`ifdef LOSS_ACC_EN
    localparam logic [15:0] LOSS_NEG1 = 16'h0200;
    localparam logic [15:0] LOSS_SAT  = 16'h7FFF;
`else
    localparam logic [15:0] LOSS_NEG1 = 16'h0000;
    localparam logic [15:0] LOSS_SAT  = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nn_phase_scheduler_if #(.BITS(BITS), .N_SAMPLES(NS), .N_EPOCHS(NE)) ifc ();

    nn_phase_scheduler #(
        .BITS(BITS), .N_SAMPLES(NS), .N_EPOCHS(NE), .FP_CYC(FP), .BP_CYC(BP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int checks = 0;
    int errors = 0;

    // {smp_ld, fph, fpo, bpo, bph, busy, done}
    logic [6:0] flags;
    assign flags = {ifc.smp_ld, ifc.fph, ifc.fpo, ifc.bpo, ifc.bph, ifc.busy, ifc.done};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Train sample: LOAD, fph x2, fpo x2, bpo x3, bph x3, NEXT (12 cycles).
    function automatic logic [6:0] train_flags(input int c);
        int p;
        if (c == 49) return 7'b0000011;
        if (c < 1 || c > 48) return 7'b0000000;
        p = (c - 1) % 12;
        if (p == 0)  return 7'b1000010;
        if (p <= 2)  return 7'b0100010;
        if (p <= 4)  return 7'b0010010;
        if (p <= 7)  return 7'b0001010;
        if (p <= 10) return 7'b0000110;
        return 7'b0000010;
    endfunction

    // Validate sample: LOAD, fph x2, fpo x2, NEXT (6 cycles).
    function automatic logic [6:0] val_flags(input int c);
        int p;
        if (c == 13) return 7'b0000011;
        if (c < 1 || c > 12) return 7'b0000000;
        p = (c - 1) % 6;
        if (p == 0) return 7'b1000010;
        if (p <= 2) return 7'b0100010;
        if (p <= 4) return 7'b0010010;
        return 7'b0000010;
    endfunction

    initial begin
        ifc.start   = 1'b0;
        ifc.stop    = 1'b0;
        ifc.tr_mode = 1'b0;
        ifc.err     = '0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        chk("reset flags", flags, 7'b0);
        chk("reset smp_idx", ifc.smp_idx, 0);
        chk("reset epoch_cnt", ifc.epoch_cnt, 0);
        chk("reset epoch_loss", ifc.epoch_loss, 16'h0000);

        // Train run; a start pulse and tr_mode change mid-run must be ignored.
        ifc.tr_mode = 1'b1;
        ifc.err     = 16'h0000 - Q_ONE;
        ifc.start   = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            chk($sformatf("train c%0d flags", c), flags, train_flags(c));
            chk($sformatf("train c%0d smp_idx", c), ifc.smp_idx, (c <= 48) ? ((c - 1) / 12) % 2 : 0);
            chk($sformatf("train c%0d epoch", c), ifc.epoch_cnt, (c <= 48) ? (c - 1) / 24 : 1);
            if (c == 24) chk("train c24 loss", ifc.epoch_loss, 16'h0000);
            if (c == 25 || c == 50) chk($sformatf("train c%0d loss", c), ifc.epoch_loss, LOSS_NEG1);
            ifc.start   = (c == 5);
            ifc.tr_mode = (c < 6);
            tick();
        end
        ifc.start = 1'b0;

        // Validate run with most-negative error.
        ifc.tr_mode = 1'b0;
        ifc.err     = 16'h8000;
        ifc.start   = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("val c%0d flags", c), flags, val_flags(c));
            chk($sformatf("val c%0d smp_idx", c), ifc.smp_idx, (c <= 12) ? (c - 1) / 6 : 0);
            chk($sformatf("val c%0d epoch", c), ifc.epoch_cnt, 0);
            if (c == 12) chk("val c12 loss", ifc.epoch_loss, LOSS_NEG1);
            if (c == 13) chk("val c13 loss", ifc.epoch_loss, LOSS_SAT);
            tick();
        end

        // Stop during bpo at cycle 7.
        ifc.tr_mode = 1'b1;
        ifc.start   = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("stop1 c%0d flags", c), flags, train_flags(c));
            if (c < 7) tick();
        end
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
        chk("stop1 c8 flags", flags, 7'b0);
        chk("stop1 c8 smp_idx", ifc.smp_idx, 0);
        chk("stop1 c8 epoch", ifc.epoch_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stop1 idle%0d flags", k), flags, 7'b0);
        end

        // Fresh start, then stop in epoch 1 to see counters clear.
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            chk($sformatf("stop2 c%0d flags", c), flags, train_flags(c));
            chk($sformatf("stop2 c%0d epoch", c), ifc.epoch_cnt, (c - 1) / 24);
            if (c < 30) tick();
        end
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
        chk("stop2 after flags", flags, 7'b0);
        chk("stop2 after epoch", ifc.epoch_cnt, 0);
        chk("stop2 after smp_idx", ifc.smp_idx, 0);

        // Asynchronous reset in the middle of FWD_H.
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        tick();
        chk("rst pre fph", flags, 7'b0100010);
        #2 rst = 1'b1;
        #1;
        chk("rst async flags", flags, 7'b0);
        chk("rst async epoch_loss", ifc.epoch_loss, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        chk("rst release flags", flags, 7'b0);

        // start together with stop in IDLE must not launch a run.
        ifc.start = 1'b1;
        ifc.stop  = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        chk("start+stop flags", flags, 7'b0);
        tick();
        chk("start+stop later flags", flags, 7'b0);

        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        chk("restart load flags", flags, 7'b1000010);
        tick();
        chk("restart fph flags", flags, 7'b0100010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
